// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, shifts done one bit per cycle.
// Define ALU_FLAGS_EN to build the {N,Z,C,V} flag logic; otherwise o_flags is tied to zero.
module alu_iter #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic signed [NB_DATA-1:0] i_a,
    input  logic signed [NB_DATA-1:0] i_b,
    input  logic        [NB_OP-1:0]   i_op,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic signed [NB_DATA-1:0] o_data,
    output logic        [3:0]         o_flags,
    output logic                      o_illegal
);

    localparam int NB_CNT = $clog2(NB_DATA + 1);
    localparam int MSB    = NB_DATA - 1;

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0] OP_SLL = NB_OP'(6'b000000);

    localparam logic [NB_DATA:0] SAT_LIM = (NB_DATA + 1)'(NB_DATA);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    // Shift amount is unsigned; anything at or past the word width behaves like a full-width shift.
    function automatic logic [NB_CNT-1:0] sat_shamt(input logic [NB_DATA-1:0] b);
        if ({1'b0, b} >= SAT_LIM) return NB_CNT'(NB_DATA);
        return NB_CNT'(b);
    endfunction

    state_t                      state;
    logic signed [NB_DATA-1:0]   acc;
    logic        [NB_OP-1:0]     op_q;
    logic        [NB_CNT-1:0]    cnt;
    logic signed [NB_DATA-1:0]   alu_res;
    logic                        alu_illegal;
    logic                        alu_shift;
    logic        [NB_CNT-1:0]    shamt;
    logic signed [NB_DATA-1:0]   sh_nxt;

    assign shamt = sat_shamt(i_b);

    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        alu_shift   = 1'b0;
        case (i_op)
            OP_ADD: alu_res = i_a + i_b;
            OP_SUB: alu_res = i_a - i_b;
            OP_AND: alu_res = i_a & i_b;
            OP_OR:  alu_res = i_a | i_b;
            OP_XOR: alu_res = i_a ^ i_b;
            OP_NOR: alu_res = ~(i_a | i_b);
            OP_SRA, OP_SRL, OP_SLL: begin
                alu_shift = 1'b1;
                alu_res   = i_a;
            end
            default: alu_illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (op_q)
            OP_SRA:  sh_nxt = {acc[MSB], acc[MSB:1]};
            OP_SLL:  sh_nxt = {acc[MSB-1:0], 1'b0};
            default: sh_nxt = {1'b0, acc[MSB:1]};
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic       alu_c;
    logic       alu_v;
    logic [3:0] acc_flags;
    logic [3:0] sh_flags;

    // Carry for ADD is detected as unsigned wrap (result below an operand).
    always_comb begin
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (i_op)
            OP_ADD: begin
                alu_c = $unsigned(alu_res) < $unsigned(i_a);
                alu_v = (i_a[MSB] == i_b[MSB]) && (alu_res[MSB] != i_a[MSB]);
            end
            OP_SUB: begin
                alu_c = $unsigned(i_a) < $unsigned(i_b);
                alu_v = (i_a[MSB] != i_b[MSB]) && (alu_res[MSB] != i_a[MSB]);
            end
            default: ;
        endcase
        acc_flags = alu_illegal ? 4'b0000 : {alu_res[MSB], alu_res == '0, alu_c, alu_v};
    end

    assign sh_flags = {sh_nxt[MSB], sh_nxt == '0, 2'b00};
`else
    assign o_flags = 4'b0000;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            o_ready   <= 1'b1;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_illegal <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            op_q      <= '0;
`ifdef ALU_FLAGS_EN
            o_flags   <= 4'b0000;
`endif
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    op_q    <= i_op;
                    acc     <= i_a;
                    o_ready <= 1'b0;
                    if (alu_shift && shamt != '0) begin
                        state <= EXEC;
                        cnt   <= shamt;
                    end else begin
                        state     <= DONE;
                        o_valid   <= 1'b1;
                        o_data    <= alu_res;
                        o_illegal <= alu_illegal;
`ifdef ALU_FLAGS_EN
                        o_flags   <= acc_flags;
`endif
                    end
                end
                EXEC: begin
                    acc <= sh_nxt;
                    cnt <= cnt - NB_CNT'(1);
                    if (cnt == NB_CNT'(1)) begin
                        state     <= DONE;
                        o_valid   <= 1'b1;
                        o_data    <= sh_nxt;
                        o_illegal <= 1'b0;
`ifdef ALU_FLAGS_EN
                        o_flags   <= sh_flags;
`endif
                    end
                end
                DONE: if (i_ready) begin
                    state     <= IDLE;
                    o_valid   <= 1'b0;
                    o_ready   <= 1'b1;
                    o_illegal <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 8, operand/result width (>=4).
REQ-002 The block SHALL have parameter NB_OP, default 6, opcode width.
REQ-003 The block SHALL have port i_clk, input, 1, single clock; all state updates on rising edge.
REQ-004 The block SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have ports i_a and i_b, input, NB_DATA each, signed operands; i_b is the unsigned shift amount for shift ops.
REQ-006 The block SHALL have port i_op, input, NB_OP, opcode.
REQ-007 The block SHALL have ports i_valid (input, 1) and o_ready (output, 1), the operation-request handshake.
REQ-008 The block SHALL have ports o_valid (output, 1) and i_ready (input, 1), the result handshake.
REQ-009 The block SHALL have port o_data, output, NB_DATA, signed result.
REQ-010 The block SHALL have port o_flags, output, 4, {N,Z,C,V}.
REQ-011 The block SHALL have port o_illegal, output, 1, high with o_valid when the opcode is unsupported.

Function
REQ-012 Opcodes SHALL be: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010, SLL 000000.
REQ-013 FSM states SHALL be IDLE, EXEC, DONE; o_ready=1 only in IDLE; o_valid=1 only in DONE.
REQ-014 In IDLE, i_valid&o_ready SHALL latch i_a, i_b and i_op; inputs at any other time are ignored.
REQ-015 Non-shift ops and illegal ops SHALL compute in the acceptance cycle and enter DONE; o_valid rises one cycle after acceptance.
REQ-016 Shift ops SHALL use n = min(i_b, NB_DATA); n=0 goes straight to DONE with result i_a; n>0 enters EXEC.
REQ-017 EXEC SHALL shift one bit per cycle (SRA sign-fills, SRL/SLL zero-fill) for n cycles, then enter DONE; o_valid rises 1+n cycles after acceptance.
REQ-018 The shift amount SHALL saturate: i_b>=NB_DATA gives 0 for SRL/SLL and NB_DATA copies of the sign bit for SRA.
REQ-019 ADD/SUB/AND/OR/XOR/NOR SHALL produce two's-complement results truncated to NB_DATA bits.
REQ-020 Flags: N = result MSB; Z = (result==0); ADD C = unsigned carry-out; SUB C = unsigned borrow (a<b); V = signed overflow for ADD/SUB; C=V=0 for logic and shift ops.
REQ-021 Illegal opcode SHALL produce o_data=0, o_flags=0, o_illegal=1, with 1-cycle latency.
REQ-022 In DONE, o_data, o_flags and o_illegal SHALL stay stable until o_valid&i_ready, after which the FSM returns to IDLE.
REQ-023 The block SHALL accept a new request no sooner than the cycle after a result handshake, with no overlap between operations.

Reset
REQ-024 i_reset SHALL force IDLE, o_ready=1, o_valid=0, o_data=0, o_flags=0, o_illegal=0, and clear the shift counter.
REQ-025 Reset asserted during EXEC or DONE SHALL discard the operation in progress with no result emitted; reset takes priority over i_valid.

Configuration
REQ-026 With macro ALU_FLAGS_EN defined, flag logic SHALL be compiled in per REQ-020.
REQ-027 Without ALU_FLAGS_EN, flag logic SHALL be absent and o_flags SHALL be constant 4'b0000; all other behaviour is unchanged.

Verification (NB_DATA=8, ALU_FLAGS_EN defined unless noted)
REQ-028 ADD 0x7F,0x01 -> o_data 0x80, flags N=1 Z=0 C=0 V=1, o_valid 1 cycle after accept.
REQ-029 SUB 0x05,0x07 -> 0xFE, N=1 C=1 V=0; without ALU_FLAGS_EN, o_flags=0000.
REQ-030 SRA 0x80 by 3 -> 0xF0, o_valid 4 cycles after accept; SRL 0xFF by 0x20 -> 0x00, o_valid 9 cycles after accept; SLL by 0 -> i_a after 1 cycle.
REQ-031 Result held with i_ready=0 for 5 cycles -> o_data and o_flags stable, o_ready=0, i_valid pulses ignored; handshake -> IDLE the next cycle.
REQ-032 Reset pulse during EXEC of SRL by 6 -> IDLE next cycle, o_valid never rises; op 111111 -> o_illegal=1, o_data=0.
